// File: rtl/heap_pair_fifo.sv
// Pair-input FIFO behind heap_rtl: drops sentinel words, stores real
// keys in arrival order and streams them out one word per cycle.
//
// Ports:
//   clk, rstn              clock, async active-low reset
//   clr                    sync clear of pointers, count and status
//   in_valid, din1, din2   heap output pair (din1 first in sort order)
//   m_valid, m_data        first-word-fall-through output
//   m_ready                consumer pop
//   count                  stored words (0..2^DEPTH_LOG2)
//   overflow               sticky, set when a real word is dropped
//   sentinel_cnt           saturating count of discarded sentinels
module heap_pair_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int KEY_WIDTH  = 12,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clr,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] din1,
  input  logic [DATA_WIDTH-1:0] din2,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic [15:0]           sentinel_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;

  if (KEY_WIDTH > DATA_WIDTH - 2) begin : g_bad_key
    $error("KEY_WIDTH overlaps the flag bits");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  ptr_t                  rd_ptr;
  ptr_t                  wr_ptr;

  logic                  keep1;
  logic                  keep2;
  logic                  pop;
  logic                  drop;
  logic [1:0]            kept;
  logic [1:0]            n_sent;
  logic [1:0]            written;
  logic [CW-1:0]         free;
  logic [DATA_WIDTH-1:0] w0;
  logic [16:0]           sent_sum;

  always_comb begin
    keep1    = in_valid && (din1[DATA_WIDTH-1 -: 2] == 2'b00);
    keep2    = in_valid && (din2[DATA_WIDTH-1 -: 2] == 2'b00);
    kept     = {1'b0, keep1} + {1'b0, keep2};
    n_sent   = in_valid ? (2'd2 - kept) : 2'd0;
    // free is sampled before this cycle's pop: a pop never makes
    // room for words arriving in the same cycle
    free     = CW'(DEPTH) - count;
    drop     = free < CW'(kept);
    // when short of room, free is 0 or 1 so its low bits suffice
    written  = drop ? free[1:0] : kept;
    // first kept word, din1 has priority for the single slot
    w0       = keep1 ? din1 : din2;
    pop      = m_valid && m_ready;
    sent_sum = {1'b0, sentinel_cnt} + 17'(n_sent);
  end

  assign m_valid = (count != '0);
  assign m_data  = m_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!clr) begin
      if (written != 2'd0) mem[wr_ptr] <= w0;
      if (written == 2'd2) mem[wr_ptr + ptr_t'(1)] <= din2;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      sentinel_cnt <= '0;
    end else if (clr) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      sentinel_cnt <= '0;
    end else begin
      wr_ptr <= wr_ptr + ptr_t'(written);
      rd_ptr <= rd_ptr + ptr_t'(pop);
      count  <= count + CW'(written) - CW'(pop);
      if (drop) overflow <= 1'b1;
      sentinel_cnt <= sent_sum[16] ? 16'hFFFF : sent_sum[15:0];
    end
  end

endmodule

// File: tb/tb_heap_pair_fifo.sv
// Randomized self-checking bench for heap_pair_fifo against a
// queue-based model of the keep/drop/stream rules.
module tb_heap_pair_fifo;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] din1 = '0;
  logic [15:0] din2 = '0;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_ready = 1'b0;
  logic [6:0]  count;
  logic        overflow;
  logic [15:0] sentinel_cnt;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] q[$];
  bit          m_ovf;
  int          m_scnt;

  always #5 clk = ~clk;

  heap_pair_fifo dut (
    .clk(clk), .rstn(rstn), .clr(clr),
    .in_valid(in_valid), .din1(din1), .din2(din2),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .count(count), .overflow(overflow),
    .sentinel_cnt(sentinel_cnt)
  );

  function automatic logic [15:0] word(input bit sent);
    logic [15:0] w;
    w = 16'($urandom);
    w[15:14] = sent ? 2'($urandom_range(1, 3)) : 2'b00;
    return w;
  endfunction

  function automatic logic [15:0] exp_data();
    return (q.size() != 0) ? q[0] : 16'h0000;
  endfunction

  // drive one cycle, then advance the model on the edge
  task automatic step(input bit c, input bit v,
                      input logic [15:0] a, input logic [15:0] b,
                      input bit r);
    int free;
    logic [15:0] w[2];
    clr = c; in_valid = v; din1 = a; din2 = b; m_ready = r;
    @(posedge clk);
    if (c) begin
      q.delete(); m_ovf = 0; m_scnt = 0;
    end else begin
      free = 64 - q.size();
      w[0] = a; w[1] = b;
      if (q.size() != 0 && r) void'(q.pop_front());
      if (v) begin
        for (int i = 0; i < 2; i++) begin
          if (w[i][15:14] == 2'b00) begin
            if (free > 0) begin q.push_back(w[i]); free--; end
            else m_ovf = 1;
          end else if (m_scnt < 65535) m_scnt++;
        end
      end
    end
    #1;
    clr = 0; in_valid = 0; m_ready = 0;
  endtask

  task automatic test_reset();
    rstn = 0; #7;
    n_chk++;
    if (m_valid !== 1'b0 || count !== 7'd0 || m_data !== 16'h0 ||
        overflow !== 1'b0 || sentinel_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL reset: mv=%b cnt=%0d data=%h ovf=%b sc=%0d want 0",
               m_valid, count, m_data, overflow, sentinel_cnt);
    end
    @(negedge clk); rstn = 1;
    q.delete(); m_ovf = 0; m_scnt = 0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    step(0, 1, 16'h0005, 16'h0009, 0);
    n_chk++;
    if (count !== 7'd2 || m_valid !== 1'b1 || m_data !== 16'h0005) begin
      n_fail++;
      $display("FAIL basic_load: cnt=%0d mv=%b data=%h want 2 1 0005",
               count, m_valid, m_data);
    end
    step(0, 0, 0, 0, 1);
    n_chk++;
    if (m_data !== 16'h0009 || count !== 7'd1) begin
      n_fail++;
      $display("FAIL basic_pop1: data=%h cnt=%0d want 0009 1",
               m_data, count);
    end
    step(0, 0, 0, 0, 1);
    n_chk++;
    if (count !== 7'd0 || m_valid !== 1'b0 || m_data !== 16'h0) begin
      n_fail++;
      $display("FAIL basic_empty: cnt=%0d mv=%b data=%h want 0 0 0",
               count, m_valid, m_data);
    end
  endtask

  task automatic test_sentinel();
    step(1, 0, 0, 0, 0);
    step(0, 1, 16'h4000, 16'h0123, 0);
    n_chk++;
    if (count !== 7'd1 || m_data !== 16'h0123 || sentinel_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL sent_mix: cnt=%0d data=%h sc=%0d want 1 0123 1",
               count, m_data, sentinel_cnt);
    end
    step(0, 1, 16'hCFFF, 16'hCFFF, 0);
    n_chk++;
    if (count !== 7'd1 || sentinel_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL sent_both: cnt=%0d sc=%0d want 1 3",
               count, sentinel_cnt);
    end
    // in_valid low: flagged words are ignored entirely
    step(0, 0, 16'h8000, 16'h8000, 0);
    n_chk++;
    if (sentinel_cnt !== 16'd3 || count !== 7'd1) begin
      n_fail++;
      $display("FAIL sent_idle: sc=%0d cnt=%0d want 3 1",
               sentinel_cnt, count);
    end
  endtask

  task automatic test_overflow();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) step(0, 1, word(0), word(0), 0);
    n_chk++;
    if (count !== 7'd64 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_full: cnt=%0d ovf=%b want 64 0", count, overflow);
    end
    step(0, 1, word(0), word(0), 0);
    n_chk++;
    if (count !== 7'd64 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: cnt=%0d ovf=%b want 64 1", count, overflow);
    end
    for (int i = 0; i < 64; i++) begin
      n_chk++;
      if (m_valid !== 1'b1 || m_data !== exp_data()) begin
        n_fail++;
        $display("FAIL ovf_drain[%0d]: mv=%b data=%h want 1 %h",
                 i, m_valid, m_data, exp_data());
      end
      step(0, 0, 0, 0, 1);
    end
    n_chk++;
    if (count !== 7'd0 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: cnt=%0d ovf=%b want 0 1", count, overflow);
    end
    step(1, 0, 0, 0, 0);
    n_chk++;
    if (overflow !== 1'b0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clr: ovf=%b mv=%b want 0 0", overflow, m_valid);
    end
  endtask

  task automatic test_partial();
    logic [15:0] a, b;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 31; i++) step(0, 1, word(0), word(0), 0);
    step(0, 1, word(0), word(1), 0);
    n_chk++;
    if (count !== 7'd63) begin
      n_fail++;
      $display("FAIL part_63: cnt=%0d want 63", count);
    end
    a = word(0); b = word(0);
    step(0, 1, a, b, 0);
    n_chk++;
    if (count !== 7'd64 || overflow !== 1'b1 || q[63] !== a) begin
      n_fail++;
      $display("FAIL part_fit: cnt=%0d ovf=%b want 64 1", count, overflow);
    end
    for (int i = 0; i < 64; i++) begin
      n_chk++;
      if (m_data !== exp_data()) begin
        n_fail++;
        $display("FAIL part_drain[%0d]: data=%h want %h",
                 i, m_data, exp_data());
      end
      step(0, 0, 0, 0, 1);
    end
    n_chk++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL part_empty: mv=%b want 0 (B leaked)", m_valid);
    end
  endtask

  task automatic test_concurrent();
    step(1, 0, 0, 0, 0);
    // single word then pop-while-writing-2 at count 1
    step(0, 1, word(0), word(1), 0);
    step(0, 1, word(0), word(0), 1);
    n_chk++;
    if (count !== 7'd2 || m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL conc_edge: cnt=%0d mv=%b want 2 1", count, m_valid);
    end
    for (int i = 0; i < 180; i++) begin
      n_chk++;
      if (m_valid !== (q.size() != 0) || m_data !== exp_data() ||
          int'(count) != q.size() || count > 7'd64) begin
        n_fail++;
        $display("FAIL conc[%0d]: mv=%b data=%h cnt=%0d want %h cnt %0d",
                 i, m_valid, m_data, count, exp_data(), q.size());
      end
      if (i < 100)
        step(0, 1, word($urandom_range(0, 7) == 0),
             word($urandom_range(0, 7) == 0), 1);
      else
        step(0, 0, 0, 0, 1);
    end
    n_chk++;
    if (overflow !== m_ovf || int'(sentinel_cnt) != m_scnt) begin
      n_fail++;
      $display("FAIL conc_status: ovf=%b sc=%0d want %b %0d",
               overflow, sentinel_cnt, m_ovf, m_scnt);
    end
  endtask

  task automatic test_async_reset();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, word(0), word(0), 0);
    n_chk++;
    if (count !== 7'd10) begin
      n_fail++;
      $display("FAIL ares_pre: cnt=%0d want 10", count);
    end
    #2 rstn = 0;
    #1;
    n_chk++;
    if (m_valid !== 1'b0 || count !== 7'd0) begin
      n_fail++;
      $display("FAIL ares_now: mv=%b cnt=%0d want 0 0", m_valid, count);
    end
    @(negedge clk); rstn = 1;
    q.delete(); m_ovf = 0; m_scnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1);
      n_chk++;
      if (m_valid !== 1'b0 || m_data !== 16'h0) begin
        n_fail++;
        $display("FAIL ares_idle[%0d]: mv=%b data=%h want 0 0",
                 i, m_valid, m_data);
      end
    end
    step(0, 1, 16'h0ABC, 16'h4000, 0);
    n_chk++;
    if (m_valid !== 1'b1 || m_data !== 16'h0ABC || count !== 7'd1) begin
      n_fail++;
      $display("FAIL ares_new: mv=%b data=%h cnt=%0d want 1 0abc 1",
               m_valid, m_data, count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sentinel();
    test_overflow();
    test_partial();
    test_concurrent();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/heap_pair_fifo.md
Name: heap_pair_fifo

Overview:
- Output buffer directly downstream of heap_rtl in the heapsort_with_fifo datapath.
- Captures the two sorted words (dout1, dout2) the heap emits per valid cycle and strips init/flush sentinel entries (flag bits != 2'b00).
- Stores the surviving keys in order and presents them one word per cycle on a valid/ready stream to the consumer.
- The heap has no backpressure, so overflow is flagged and excess words are dropped, never stalled.

Parameters:
- DATA_WIDTH, 16, heap entry width: flag bits [DATA_WIDTH-1:DATA_WIDTH-2], key bits [KEY_WIDTH-1:0].
- KEY_WIDTH, 12, key field width. Bits between the flags and the key pass through unchanged.
- DEPTH_LOG2, 6, log2 of buffer depth (64 entries).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous clear of pointers, count and status.
- in_valid  in  1  heap valid; din1/din2 are meaningful this cycle.
- din1  in  DATA_WIDTH  first heap output word (earlier in sort order).
- din2  in  DATA_WIDTH  second heap output word.
- m_valid  out  1  output word available.
- m_data  out  DATA_WIDTH  output word.
- m_ready  in  1  consumer accepts m_data this cycle.
- count  out  DEPTH_LOG2+1  number of stored words.
- overflow  out  1  sticky; one or more real words were dropped because the buffer was full.
- sentinel_cnt  out  16  saturating count of discarded sentinel words.

Behaviour:
- Reset (rstn low, async): rd_ptr=0, wr_ptr=0, count=0, m_valid=0, m_data=0, overflow=0, sentinel_cnt=0. Storage array is not reset.
- Keep rule: a word is kept iff in_valid=1 and its flag bits == 2'b00. Otherwise, if in_valid=1, it is a sentinel; sentinel_cnt increments by the number of sentinels (0..2), saturating at 16'hFFFF.
- Write order: din1 before din2. With k kept words (0..2), they are written at wr_ptr and wr_ptr+1, and wr_ptr advances by the number actually written. Pointers wrap modulo 2^DEPTH_LOG2.
- Space check: free = 2^DEPTH_LOG2 - count, taken at the start of the cycle. A pop in the same cycle does not create space for that cycle's writes.
- Space limit: if k > free, write the first free kept words (din1 priority), drop the rest, and set overflow. It stays 1 until clr or reset.
- Output is first-word-fall-through:
  - m_valid = (count != 0).
  - m_data = mem[rd_ptr] when m_valid, else 0.
  - Both are derived from registered state; no combinational path from din or m_ready.
- Pop: m_valid && m_ready advances rd_ptr by 1. m_ready with m_valid=0 is ignored.
- Count update: count_next = count + written - popped. Range 0..2^DEPTH_LOG2; the full condition is count == 2^DEPTH_LOG2.
- Simultaneous write and pop are both applied in the same cycle. With count=1, popping the last word while writing 2 gives count=2, and m_valid stays 1.
- clr=1 takes priority over writes and pops that cycle:
  - Next state: pointers=0, count=0, overflow=0, sentinel_cnt=0.
  - m_valid=0 on the following cycle.
- Reset mid-operation: all state returns to reset values immediately. Any words in flight are lost.
- Data is never modified. Word order out equals kept-word arrival order.

Test Plan:
- After reset, in_valid=1 with din1=16'h0005, din2=16'h0009, m_ready=0 -> next cycle count=2, m_valid=1, m_data=16'h0005. m_ready=1 for 2 cycles -> outputs 0005 then 0009, then count=0, m_valid=0.
- Sentinel filtering: din1=16'h4000 (init sentinel, 2'b01), din2=16'h0123 -> only 0123 stored, sentinel_cnt=1. Then din1=din2=16'hCFFF -> nothing stored, sentinel_cnt=3.
- Overflow: m_ready=0, 32 cycles of two real words fill 64 entries (count=64). One more pair -> count stays 64, overflow=1. Drain all 64 -> order matches input, overflow still 1. Pulse clr -> overflow=0.
- Partial fit: fill to count=63, then a pair A,B -> A stored, B dropped, count=64, overflow=1.
- Concurrent and wrap-around: m_ready=1 continuously, 100 cycles of random pairs with a 2:1 ratio held near full and then drained. Compare the output stream against a scoreboard across pointer wraps; count never exceeds 64.
- Async reset mid-stream: assert rstn=0 between clock edges with count=10 -> m_valid=0 and count=0 immediately, with no output after release until new input arrives.
